// File: rtl/draw_hud_counter_if.sv
// VGA timing/colour bundle passed between drawing stages.
// Stages take the "in" view upstream and drive the "out" view downstream.
interface vga_if;
    logic [10:0] hcount;
    logic [10:0] vcount;
    logic        hsync;
    logic        vsync;
    logic        hblnk;
    logic        vblnk;
    logic [11:0] rgb;

    modport in  (input  hcount, vcount, hsync, vsync, hblnk, vblnk, rgb);
    modport out (output hcount, vcount, hsync, vsync, hblnk, vblnk, rgb);
endinterface

// File: rtl/draw_hud_counter.sv
// HUD overlay: draws "<label><decimal value>" in a box on the VGA stream, 3-clk pipeline.
// Optional HUD_BLINK_EN macro blinks the digits while the committed value is below WARN_LEVEL.
//
// state  | meaning
// IDLE   | waiting for the next vblnk rising edge
// SHIFT  | double-dabble: one shadow bit per clk, MSB first
// COMMIT | load finished BCD (or all nines) into the displayed digits
module draw_hud_counter #(
    parameter int          VALUE_W     = 10,
    parameter int          NUM_DIGITS  = 3,
    parameter int          LABEL_LEN   = 3,
    parameter logic [55:0] LABEL_CODES = 56'({7'h48, 7'h50, 7'h20}),
    parameter int          X_POS       = 150,
    parameter int          Y_POS       = 650,
    parameter int          SCALE_LOG2  = 1,
    parameter logic [11:0] FG_COLOR    = 12'hFFF,
    parameter logic [11:0] BG_COLOR    = 12'h0F0,
    parameter int          WARN_LEVEL  = 3
) (
    input  logic               clk,
    input  logic               rst,
    vga_if.in                  in,
    vga_if.out                 out,
    input  logic [VALUE_W-1:0] value,
    output logic [10:0]        addr,
    input  logic [7:0]         char_line_pixels
);

    localparam int              BCD_W    = 4 * NUM_DIGITS;
    localparam int              CHARS    = LABEL_LEN + NUM_DIGITS;
    localparam logic [11:0]     X_LO     = 12'(X_POS);
    localparam logic [11:0]     X_HI     = 12'(X_POS + CHARS * (8 << SCALE_LOG2));
    localparam logic [11:0]     Y_LO     = 12'(Y_POS);
    localparam logic [11:0]     Y_HI     = 12'(Y_POS + (16 << SCALE_LOG2));
    localparam logic [31:0]     MAX_VAL  = 32'(10 ** NUM_DIGITS - 1);
    localparam int              CNT_W    = (VALUE_W > 1) ? $clog2(VALUE_W) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(VALUE_W - 1);
    localparam logic [BCD_W-1:0] ALL9    = {NUM_DIGITS{4'h9}};

    typedef struct packed {
        logic [10:0] hcount;
        logic [10:0] vcount;
        logic        hsync;
        logic        vsync;
        logic        hblnk;
        logic        vblnk;
        logic [11:0] rgb;
    } timing_t;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1,
        COMMIT = 2'd2
    } state_t;

    timing_t cur, s1, s2;
    assign cur = {in.hcount, in.vcount, in.hsync, in.vsync, in.hblnk, in.vblnk, in.rgb};

    state_t            state, state_next;
    logic              vblnk_prev;
    logic              vblnk_rise;
    logic [VALUE_W-1:0] shadow;
    logic [BCD_W-1:0]  bcd_sr;
    logic [BCD_W-1:0]  bcd_adj;
    logic [CNT_W-1:0]  bit_cnt;
    logic [BCD_W-1:0]  digits;
    logic              sat;
    logic              hide_digits;

    assign vblnk_rise = in.vblnk & ~vblnk_prev;
    assign sat        = 32'(shadow) > MAX_VAL;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // A new vblnk edge always wins: an unfinished conversion is simply restarted.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    state_next = IDLE;
            SHIFT:   if (bit_cnt == '0) state_next = COMMIT;
            COMMIT:  state_next = IDLE;
            default: state_next = IDLE;
        endcase
        if (vblnk_rise) state_next = SHIFT;
    end

    always_comb begin
        bcd_adj = bcd_sr;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (bcd_sr[i*4 +: 4] >= 4'd5) bcd_adj[i*4 +: 4] = bcd_sr[i*4 +: 4] + 4'd3;
        end
    end

    // Bits carried out of the top digit are dropped; overflow is handled by the saturation compare.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vblnk_prev <= 1'b0;
            shadow     <= '0;
            bcd_sr     <= '0;
            bit_cnt    <= '0;
            digits     <= '0;
        end else begin
            vblnk_prev <= in.vblnk;
            if (vblnk_rise) begin
                shadow  <= value;
                bcd_sr  <= '0;
                bit_cnt <= CNT_LAST;
            end else if (state == SHIFT) begin
                bcd_sr  <= BCD_W'({bcd_adj, shadow[bit_cnt]});
                bit_cnt <= bit_cnt - 1'b1;
            end else if (state == COMMIT) begin
                digits  <= sat ? ALL9 : bcd_sr;
            end
        end
    end

`ifdef HUD_BLINK_EN
    localparam logic [31:0] WARN_U = 32'(WARN_LEVEL);
    logic [4:0] frame_cnt;
    logic       warn_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            frame_cnt <= '0;
            warn_q    <= (WARN_U != 32'd0);
        end else begin
            if (vblnk_rise) frame_cnt <= frame_cnt + 5'd1;
            if (state == COMMIT) warn_q <= (32'(shadow) < WARN_U);
        end
    end

    assign hide_digits = warn_q & frame_cnt[4];
`else
    assign hide_digits = 1'b0;
`endif

    // Stage 1: character/glyph addressing relative to the box origin.
    logic [10:0] dx, dy, col_x;
    logic [7:0]  char_idx;
    logic [2:0]  col;
    logic [3:0]  glyph_line;
    logic        in_box;

    assign dx         = in.hcount - 11'(X_POS);
    assign dy         = in.vcount - 11'(Y_POS);
    assign col_x      = dx >> SCALE_LOG2;
    assign char_idx   = col_x[10:3];
    assign col        = col_x[2:0];
    assign glyph_line = 4'(dy >> SCALE_LOG2);
    assign in_box     = ({1'b0, in.hcount} >= X_LO) && ({1'b0, in.hcount} < X_HI) &&
                        ({1'b0, in.vcount} >= Y_LO) && ({1'b0, in.vcount} < Y_HI);

    // lead_blank[0] is the most significant digit; the last digit is never blanked.
    logic [NUM_DIGITS-1:0] lead_blank;
    always_comb begin : blank_calc
        logic zero_run;
        zero_run   = 1'b1;
        lead_blank = '0;
        for (int i = 0; i < NUM_DIGITS - 1; i++) begin
            zero_run      = zero_run && (digits[(NUM_DIGITS-1-i)*4 +: 4] == 4'd0);
            lead_blank[i] = zero_run;
        end
    end

    logic [6:0] char_code;
    logic       is_digit;
    always_comb begin
        char_code = 7'h20;
        is_digit  = 1'b0;
        for (int i = 0; i < LABEL_LEN; i++) begin
            if (char_idx == 8'(i)) char_code = LABEL_CODES[(LABEL_LEN-1-i)*7 +: 7];
        end
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (char_idx == 8'(LABEL_LEN + i)) begin
                is_digit  = 1'b1;
                char_code = lead_blank[i] ? 7'h20 : {3'b011, digits[(NUM_DIGITS-1-i)*4 +: 4]};
            end
        end
    end

    logic       s1_in_box, s2_in_box;
    logic [2:0] s1_col, s2_col;
    logic       s1_is_digit, s2_is_digit;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1          <= '0;
            s1_in_box   <= 1'b0;
            s1_col      <= '0;
            s1_is_digit <= 1'b0;
            addr        <= '0;
            s2          <= '0;
            s2_in_box   <= 1'b0;
            s2_col      <= '0;
            s2_is_digit <= 1'b0;
        end else begin
            s1          <= cur;
            s1_in_box   <= in_box;
            s1_col      <= col;
            s1_is_digit <= is_digit;
            if (in_box) addr <= {char_code, glyph_line};
            s2          <= s1;
            s2_in_box   <= s1_in_box;
            s2_col      <= s1_col;
            s2_is_digit <= s1_is_digit;
        end
    end

    // Stage 3: font row arrives now, bit 7 is the leftmost pixel.
    logic        pix_on;
    logic [11:0] rgb_next;
    always_comb begin
        pix_on   = char_line_pixels[3'd7 - s2_col];
        rgb_next = s2.rgb;
        if (s2_in_box) begin
            rgb_next = (pix_on && !(s2_is_digit && hide_digits)) ? FG_COLOR : BG_COLOR;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out.hcount <= '0;
            out.vcount <= '0;
            out.hsync  <= 1'b0;
            out.vsync  <= 1'b0;
            out.hblnk  <= 1'b0;
            out.vblnk  <= 1'b0;
            out.rgb    <= '0;
        end else begin
            out.hcount <= s2.hcount;
            out.vcount <= s2.vcount;
            out.hsync  <= s2.hsync;
            out.vsync  <= s2.vsync;
            out.hblnk  <= s2.hblnk;
            out.vblnk  <= s2.vblnk;
            out.rgb    <= rgb_next;
        end
    end

endmodule

// File: tb/tb_draw_hud_counter.sv
// Scoreboard bench for draw_hud_counter on a shrunken 128x44 raster with a synthetic font ROM.
module tb_draw_hud_counter;
    localparam int XP = 16, YP = 4, SL = 1;
    localparam int H_TOT = 128, H_ACT = 120, V_TOT = 44, V_ACT = 40, FRAMES = 7;
    localparam logic [11:0] FG = 12'hFC0, BG = 12'h0F0;

    typedef struct { int due; logic [37:0] data; } vid_item_t;
    typedef struct { int due; logic [10:0] data; } adr_item_t;
    vid_item_t vid_q[$];
    adr_item_t adr_q[$];
    adr_item_t adr0_q[$];

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [9:0]  value = '0;
    logic [10:0] addr, addr0;
    logic [7:0]  clp = '0, clp0 = '0;
    int          cyc = 0;
    int          checks = 0;
    int          errors = 0;

    vga_if vin();
    vga_if vout();
    vga_if vout0();

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    draw_hud_counter #(.X_POS(XP), .Y_POS(YP), .SCALE_LOG2(SL), .FG_COLOR(FG), .BG_COLOR(BG)) dut (
        .clk(clk), .rst(rst), .in(vin), .out(vout), .value(value),
        .addr(addr), .char_line_pixels(clp));

    draw_hud_counter #(.X_POS(XP), .Y_POS(YP), .SCALE_LOG2(0), .FG_COLOR(FG), .BG_COLOR(BG)) dut0 (
        .clk(clk), .rst(rst), .in(vin), .out(vout0), .value(value),
        .addr(addr0), .char_line_pixels(clp0));

    function automatic logic [7:0] font(input logic [10:0] a);
        return a[10:3] ^ {a[3:0], a[6:3]} ^ 8'h96;
    endfunction

    always @(posedge clk) begin
        clp  <= font(addr);
        clp0 <= font(addr0);
    end

    function automatic logic [6:0] char_of(input int idx, input int d);
        int hd, td, od;
        hd = d / 100;
        td = (d / 10) % 10;
        od = d % 10;
        case (idx)
            0: return 7'h48;
            1: return 7'h50;
            2: return 7'h20;
            3: return (hd == 0) ? 7'h20 : 7'(48 + hd);
            4: return (hd == 0 && td == 0) ? 7'h20 : 7'(48 + td);
            default: return 7'(48 + od);
        endcase
    endfunction

    always @(negedge clk) begin : monitor
        vid_item_t   vi;
        adr_item_t   ai;
        logic [37:0] got;
        got = {vout.hcount, vout.vcount, vout.hsync, vout.vsync, vout.hblnk, vout.vblnk, vout.rgb};
        if (vid_q.size() > 0 && vid_q[0].due <= cyc) begin
            vi = vid_q.pop_front();
            checks++;
            if (vi.due != cyc || got !== vi.data) begin
                errors++;
                $display("FAIL video cyc=%0d got=%h want=%h due=%0d", cyc, got, vi.data, vi.due);
            end
        end
        if (adr_q.size() > 0 && adr_q[0].due <= cyc) begin
            ai = adr_q.pop_front();
            checks++;
            if (ai.due != cyc || addr !== ai.data) begin
                errors++;
                $display("FAIL addr cyc=%0d got=%h want=%h due=%0d", cyc, addr, ai.data, ai.due);
            end
        end
        if (adr0_q.size() > 0 && adr0_q[0].due <= cyc) begin
            ai = adr0_q.pop_front();
            checks++;
            if (ai.due != cyc || addr0 !== ai.data) begin
                errors++;
                $display("FAIL addr_scale0 cyc=%0d got=%h want=%h due=%0d", cyc, addr0, ai.data, ai.due);
            end
        end
    end

    task automatic push_zero();
        vid_q.push_back('{due: cyc, data: '0});
        adr_q.push_back('{due: cyc, data: '0});
        adr0_q.push_back('{due: cyc, data: '0});
    endtask

    initial begin : driver
        int          val_a[FRAMES];
        int          val_b[FRAMES];
        int          disp;
        logic        prev_vbl, vbl, hs, vs, hb, bitv;
        logic [10:0] adr_model, a;
        logic [11:0] rgb_in, rgb_exp;
        logic [7:0]  fb;
        int          cx, idx, col, line;

        // value before/after line 20 of each frame; frame f+1 shows what frame f held at vblnk
        val_a = '{9, 9, 1023, 100, 500, 42, 7};
        val_b = '{9, 127, 1023, 100, 500, 42, 7};
        disp = 0;
        prev_vbl = 1'b0;
        adr_model = '0;

        vin.hcount = '0; vin.vcount = '0; vin.hsync = 1'b0; vin.vsync = 1'b0;
        vin.hblnk = 1'b0; vin.vblnk = 1'b0; vin.rgb = '0;

        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            push_zero();
        end
        @(posedge clk); #1;
        rst = 1'b0;

        for (int f = 0; f < FRAMES; f++) begin
            for (int v = 0; v < V_TOT; v++) begin
                for (int h = 0; h < H_TOT; h++) begin
                    // reset lands a few clk into the conversion of 500 and holds until vblank ends
                    if (f == 4 && v == V_ACT && h == 4) begin
                        rst = 1'b1;
                        vid_q.delete();
                        adr_q.delete();
                        adr0_q.delete();
                    end
                    if (f == 5 && v == 0 && h == 0 && rst) begin
                        rst = 1'b0;
                        disp = 0;
                        prev_vbl = 1'b0;
                        adr_model = '0;
                    end

                    value  = 10'((v < 20) ? val_a[f] : val_b[f]);
                    vbl    = (v >= V_ACT);
                    hb     = (h >= H_ACT);
                    hs     = (h >= 122 && h < 126);
                    vs     = (v == 41);
                    rgb_in = {6'(h), 6'(v)};
                    vin.hcount = 11'(h); vin.vcount = 11'(v);
                    vin.hsync = hs; vin.vsync = vs; vin.hblnk = hb; vin.vblnk = vbl;
                    vin.rgb = rgb_in;

                    if (rst) begin
                        push_zero();
                    end else begin
                        if (vbl && !prev_vbl) disp = (int'(value) > 999) ? 999 : int'(value);
                        prev_vbl = vbl;
                        rgb_exp = rgb_in;
                        if (h >= XP && h < XP + 96 && v >= YP && v < YP + 32) begin
                            cx   = (h - XP) >> SL;
                            idx  = cx >> 3;
                            col  = cx & 7;
                            line = ((v - YP) >> SL) & 15;
                            a    = {char_of(idx, disp), 4'(line)};
                            adr_model = a;
                            fb   = font(a);
                            bitv = fb[7 - col];
                            rgb_exp = bitv ? FG : BG;
                        end
                        vid_q.push_back('{due: cyc + 3,
                            data: {11'(h), 11'(v), hs, vs, hb, vbl, rgb_exp}});
                        adr_q.push_back('{due: cyc + 1, data: adr_model});
                        if (h == XP + 8 && v == YP)
                            adr0_q.push_back('{due: cyc + 1, data: 11'h500});
                    end
                    @(posedge clk); #1;
                end
            end
        end

        repeat (6) @(posedge clk);
        #1;
        checks++;
        if (vid_q.size() != 0 || adr_q.size() != 0 || adr0_q.size() != 0) begin
            errors++;
            $display("FAIL drain got=%0d/%0d/%0d pending want=0", vid_q.size(), adr_q.size(), adr0_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/draw_hud_counter.md
DRAW_HUD_COUNTER -- requirements
Module: draw_hud_counter

Interface
REQ-001 Parameter VALUE_W, 10, width of displayed unsigned value.
REQ-002 Parameter NUM_DIGITS, 3, decimal digit count, 1..4.
REQ-003 Parameter LABEL_LEN, 3, label character count, 0..8.
REQ-004 Parameter LABEL_CODES, {H,P,SPACE}, packed 7-bit font codes, leftmost char in MSBs.
REQ-005 Parameter X_POS / Y_POS, 150 / 650, top-left pixel of text box.
REQ-006 Parameter SCALE_LOG2, 1, glyph magnification 2**SCALE_LOG2, 0..2.
REQ-007 Parameter FG_COLOR / BG_COLOR, MENU_TEXT_COLOR / COLOR_GREEN, 12-bit glyph / box colours.
REQ-008 Parameter WARN_LEVEL, 3, blink threshold (used only with HUD_BLINK_EN).
REQ-009 clk  input  1  pixel clock; all logic on rising edge.
REQ-010 rst  input  1  reset, asynchronous, active-high.
REQ-011 in  vga_if.in  -  upstream timing and rgb.
REQ-012 out  vga_if.out  -  downstream timing and rgb.
REQ-013 value  input  VALUE_W  number to display, sampled once per frame.
REQ-014 addr  output  11  font ROM address {char_code[6:0], glyph_line[3:0]}.
REQ-015 char_line_pixels  input  8  font ROM row, valid 1 clk after addr, bit 7 = leftmost pixel.

Function
REQ-016 out.hcount/vcount/hsync/vsync/hblnk/vblnk SHALL equal in.* delayed exactly 3 clk.
REQ-017 out.rgb SHALL equal in.rgb delayed 3 clk outside box; box = X_POS<=hcount<X_POS+(LABEL_LEN+NUM_DIGITS)*8*2**SCALE_LOG2, Y_POS<=vcount<Y_POS+16*2**SCALE_LOG2.
REQ-018 Inside box: glyph bit set -> FG_COLOR, else BG_COLOR.
REQ-019 Stage 1: char index = (hcount-X_POS)>>(3+SCALE_LOG2); glyph_line = ((vcount-Y_POS)>>SCALE_LOG2)[3:0]; addr registered; column ((hcount-X_POS)>>SCALE_LOG2)[2:0] carried 2 stages to select char_line_pixels[7-col].
REQ-020 Char index < LABEL_LEN -> LABEL_CODES entry; else digit (index-LABEL_LEN), most significant first, code = "0"+digit.
REQ-021 Leading zeros SHALL be replaced by SPACE; least significant digit always drawn (value 0 -> "  0").
REQ-022 Rising edge of in.vblnk SHALL capture value into shadow register and start sequential binary-to-BCD FSM.
REQ-023 FSM states IDLE -> SHIFT (VALUE_W clk, add-3-then-shift) -> COMMIT (1 clk, digit register load) -> IDLE; done within VALUE_W+2 clk.
REQ-024 Displayed digit register SHALL change only in COMMIT; never during active video of a frame.
REQ-025 Shadow value > 10**NUM_DIGITS-1 SHALL saturate: all digits 9.
REQ-026 vblnk rising edge while FSM busy SHALL restart conversion with new sample; partial result discarded.
REQ-027 Outside box, addr SHALL hold its last value (no spurious toggling requirement beyond this).

Reset
REQ-028 During rst: out.* = 0, addr = 0, shadow = 0, FSM = IDLE, all pipeline regs = 0.
REQ-029 Digit register SHALL reset to 0 (display "  0" until first COMMIT).
REQ-030 rst mid-conversion SHALL abort to IDLE; no COMMIT follows.
REQ-031 Frame counter (if compiled) SHALL reset to 0.

Configuration
REQ-032 Macro HUD_BLINK_EN defined: 5-bit frame counter increments on each vblnk rising edge, wraps 31->0; when committed value < WARN_LEVEL and counter[4]=1, digit positions drawn as BG_COLOR (label unaffected).
REQ-033 Macro HUD_BLINK_EN undefined: no frame counter, digits always drawn; WARN_LEVEL ignored.

Verification
REQ-034 rst high 5 clk, then frame with value=0 -> box shows label "HP " + "  0"; out.* = in.* delayed 3 clk checked every cycle.
REQ-035 value=9 frame, change to 127 mid-active-video -> current frame digits stay "  9"; next frame "127".
REQ-036 value=1023, NUM_DIGITS=3 -> "999"; value=100 -> "100" (no zero suppression inside number).
REQ-037 SCALE_LOG2=0 vs 2, pixel at X_POS+8<<SCALE_LOG2 -> addr char index 1, glyph_line 0, col 0.
REQ-038 rst asserted during SHIFT (value=500) -> FSM IDLE, display "  0" next frame until new COMMIT.
REQ-039 HUD_BLINK_EN, value=2, WARN_LEVEL=3 -> digits visible frames 0-15, hidden 16-31; value=3 -> never hidden.
